// File: rtl/thread_msg_arbiter.sv
// Round-robin arbiter that serialises per-core FORK/STOP requests onto the
// shared dispatcher message channel and returns per-core done/err pulses.
module thread_msg_arbiter #(
    parameter int         N_CPU           = 4,
    parameter int         ADDR_W          = 32,
    parameter int         DATA_W          = 32,
    parameter int         TIMEOUT_CYC     = 1024,
    parameter logic [7:0] CPU_R_FORK_THRD = 8'h01,
    parameter logic [7:0] CPU_R_STOP_THRD = 8'h02,
    parameter logic [7:0] CPU_R_FORK_DONE = 8'h81,
    parameter logic [7:0] CPU_R_STOP_DONE = 8'h82
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CPU-1:0]          req_valid,
    input  logic [N_CPU-1:0]          req_op,
    input  logic [N_CPU*ADDR_W-1:0]   req_addr,
    input  logic [N_CPU*DATA_W-1:0]   req_data,
    output logic [N_CPU-1:0]          done,
    output logic [N_CPU-1:0]          err,
    output logic [N_CPU-1:0]          grant,
    input  logic                      disp_online,
    output logic [7:0]                msg_out,
    output logic [ADDR_W-1:0]         addr_out,
    output logic [DATA_W-1:0]         data_out,
    input  logic [7:0]                msg_in
);

    localparam int IDX_W = $clog2(N_CPU);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CPU - 1);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [IDX_W-1:0]    g_r, g_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_s;
    logic                op_r, op_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                err_flag_r, err_flag_s;
    logic [IDX_W-1:0]    pick_s;
    logic [7:0]          expect_s;
    logic                timeout_hit_s;

    // First set bit of v at or after ptr, wrapping modulo N_CPU.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CPU-1:0] v,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = {IDX_W{1'b0}};
        found = 1'b0;
        for (int off = 0; off < N_CPU; off++) begin
            idx   = (int'(ptr) + off) % N_CPU;
            pick  = (!found && v[idx]) ? IDX_W'(idx) : pick;
            found = found | v[idx];
        end
        return pick;
    endfunction

    function automatic logic [N_CPU-1:0] one_hot(input logic [IDX_W-1:0] idx);
        return {{(N_CPU-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-state and transaction-latch logic.
    always_comb begin
        state_s       = state_r;
        g_s           = g_r;
        rr_ptr_s      = rr_ptr_r;
        op_s          = op_r;
        addr_s        = addr_r;
        data_s        = data_r;
        cnt_s         = cnt_r;
        err_flag_s    = err_flag_r;
        pick_s        = rr_pick(req_valid, rr_ptr_r);
        expect_s      = op_r ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
        timeout_hit_s = TIMEOUT_EN && (cnt_r == CNT_LAST);
        case (state_r)
            S_IDLE: begin
                if (disp_online && (|req_valid)) begin
                    state_s = S_ISSUE;
                    g_s     = pick_s;
                    op_s    = req_op[pick_s];
                    addr_s  = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    data_s  = req_data[int'(pick_s)*DATA_W +: DATA_W];
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_s = S_WAIT;
                cnt_s   = {CNT_W{1'b0}};
            end
            S_WAIT: begin
                // A valid reply wins over a coincident timeout or drop.
                if (msg_in == expect_s) begin
                    state_s    = S_RESP;
                    err_flag_s = 1'b0;
                end else if (!disp_online || timeout_hit_s) begin
                    state_s    = S_RESP;
                    err_flag_s = 1'b1;
                end else begin
                    cnt_s = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_s  = S_IDLE;
                rr_ptr_s = (g_r == IDX_LAST) ? {IDX_W{1'b0}} : g_r + IDX_W'(1);
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state and latched transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            g_r        <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            op_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            err_flag_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            g_r        <= g_s;
            rr_ptr_r   <= rr_ptr_s;
            op_r       <= op_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            cnt_r      <= cnt_s;
            err_flag_r <= err_flag_s;
        end
    end

    // Registered outputs follow the current state one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_out  <= 8'h00;
            addr_out <= {ADDR_W{1'b0}};
            data_out <= {DATA_W{1'b0}};
            grant    <= {N_CPU{1'b0}};
            done     <= {N_CPU{1'b0}};
            err      <= {N_CPU{1'b0}};
        end else begin
            case (state_r)
                S_ISSUE: begin
                    msg_out  <= op_r ? CPU_R_STOP_THRD : CPU_R_FORK_THRD;
                    addr_out <= addr_r;
                    data_out <= data_r;
                    grant    <= one_hot(g_r);
                    done     <= {N_CPU{1'b0}};
                    err      <= {N_CPU{1'b0}};
                end
                S_WAIT: begin
                    msg_out <= 8'h00;
                    grant   <= one_hot(g_r);
                    done    <= {N_CPU{1'b0}};
                    err     <= {N_CPU{1'b0}};
                end
                S_RESP: begin
                    msg_out <= 8'h00;
                    grant   <= {N_CPU{1'b0}};
                    done    <= one_hot(g_r);
                    err     <= err_flag_r ? one_hot(g_r) : {N_CPU{1'b0}};
                end
                default: begin
                    msg_out <= 8'h00;
                    grant   <= {N_CPU{1'b0}};
                    done    <= {N_CPU{1'b0}};
                    err     <= {N_CPU{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_msg_arbiter.sv
// Directed bench for thread_msg_arbiter: table of single transactions plus
// hand sequences for reset, round-robin order and dispatcher drop.
module tb_thread_msg_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [7:0] FORK_THRD = 8'h01;
    localparam logic [7:0] STOP_THRD = 8'h02;
    localparam logic [7:0] FORK_DONE = 8'h81;
    localparam logic [7:0] STOP_DONE = 8'h82;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_op;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [N-1:0]    grant;
    logic            disp_online;
    logic [7:0]      msg_out;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   data_out;
    logic [7:0]      msg_in;

    int checks = 0;
    int errors = 0;

    thread_msg_arbiter #(
        .N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .done(done), .err(err),
        .grant(grant), .disp_online(disp_online), .msg_out(msg_out),
        .addr_out(addr_out), .data_out(data_out), .msg_in(msg_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        int          reply_at;   // WAIT cycle carrying the good reply; 0 = never
        int          wrong_n;    // leading WAIT cycles carrying the wrong done code
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int start, output int n);
        bit seen;
        n    = start;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            seen = (grant != '0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         n;
        bit         seen;
        logic [3:0] oh;
        logic [7:0] exp_msg, good, wrong;
        oh      = 4'b0001 << v.core;
        exp_msg = v.op ? STOP_THRD : FORK_THRD;
        good    = v.op ? STOP_DONE : FORK_DONE;
        wrong   = v.op ? FORK_DONE : STOP_DONE;
        req_valid[v.core]           = 1'b1;
        req_op[v.core]              = v.op;
        req_addr[v.core*AW +: AW]   = v.addr;
        req_data[v.core*DW +: DW]   = v.data;
        wait_grant(0, n);
        chk("grant_latency", 64'(n), 64'd2);
        chk("grant", 64'(grant), 64'(oh));
        chk("msg_issue", 64'(msg_out), 64'(exp_msg));
        chk("addr_out", 64'(addr_out), 64'(v.addr));
        chk("data_out", 64'(data_out), 64'(v.data));
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            n++;
            msg_in = (n == v.reply_at) ? good : ((n <= v.wrong_n) ? wrong : 8'h00);
            tick();
            if (n == 1) begin
                chk("msg_cleared", 64'(msg_out), 64'd0);
                chk("addr_hold", 64'(addr_out), 64'(v.addr));
            end
            seen = (done != '0);
        end
        msg_in = 8'h00;
        chk("done_latency", 64'(n), (v.reply_at == 0) ? 64'(TO + 1) : 64'(v.reply_at + 1));
        chk("done", 64'(done), 64'(oh));
        chk("err", 64'(err), v.exp_err ? 64'(oh) : 64'd0);
        chk("grant_cleared", 64'(grant), 64'd0);
        req_valid[v.core] = 1'b0;
        tick();
        chk("pulse_end", 64'({done, err}), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int start;
        int order[5];
        bit bad;
        order = '{0, 1, 2, 3, 0};

        vecs[0] = '{core: 1, op: 1'b0, addr: 32'h100,      data: 32'h200,      reply_at: 3, wrong_n: 0, exp_err: 1'b0};
        vecs[1] = '{core: 2, op: 1'b1, addr: 32'h0000_00A0, data: 32'h0000_00B0, reply_at: 6, wrong_n: 5, exp_err: 1'b0};
        vecs[2] = '{core: 0, op: 1'b1, addr: 32'hDEAD_0000, data: 32'h0000_BEEF, reply_at: 0, wrong_n: 0, exp_err: 1'b1};
        vecs[3] = '{core: 3, op: 1'b0, addr: 32'hFFFF_FFFF, data: 32'h8000_0001, reply_at: 1, wrong_n: 0, exp_err: 1'b0};
        vecs[4] = '{core: 2, op: 1'b0, addr: 32'h1234_5678, data: 32'h9ABC_DEF0, reply_at: 2, wrong_n: 1, exp_err: 1'b0};
        vecs[5] = '{core: 1, op: 1'b0, addr: 32'h0000_0004, data: 32'h0000_0008, reply_at: 0, wrong_n: 3, exp_err: 1'b1};

        rst         = 1'b0;
        req_valid   = '0;
        req_op      = '0;
        req_addr    = '0;
        req_data    = '0;
        disp_online = 1'b1;
        msg_in      = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_outputs", 64'({grant, done, err, msg_out}), 64'd0);
        chk("reset_addr_data", 64'({addr_out, data_out}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of WAIT: no done, next grant restarts at core 0.
        req_valid[2] = 1'b1;
        req_op[2]    = 1'b1;
        req_addr[2*AW +: AW] = 32'h5555_0000;
        wait_grant(0, n);
        chk("rst_pre_grant", 64'(grant), 64'b0100);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({grant, done, err, msg_out}), 64'd0);
        chk("rst_async_addr", 64'(addr_out), 64'd0);
        tick();
        rst = 1'b1;
        req_valid[2] = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (done != '0 || grant != '0) bad = 1'b1;
        end
        chk("rst_no_done", 64'(bad), 64'd0);

        // Round robin: all four request; core 0 re-requests after its turn.
        for (int j = 0; j < N; j++) begin
            req_valid[j]       = 1'b1;
            req_op[j]          = 1'b0;
            req_addr[j*AW +: AW] = 32'h1000 + 32'(j);
            req_data[j*DW +: DW] = 32'h2000 + 32'(j);
        end
        start = 0;
        for (int t = 0; t < 5; t++) begin
            wait_grant(start, n);
            chk("rr_gap", 64'(n), 64'd2);
            chk("rr_grant", 64'(grant), 64'(4'b0001 << order[t]));
            chk("rr_addr", 64'(addr_out), 64'(32'h1000 + 32'(order[t])));
            msg_in = FORK_DONE;
            tick();
            msg_in = 8'h00;
            tick();
            chk("rr_done", 64'(done), 64'(4'b0001 << order[t]));
            req_valid[order[t]] = 1'b0;
            start = 0;
            if (t == 0) begin
                tick();
                req_valid[0] = 1'b1;
                start = 1;
            end
        end
        tick();

        // Dispatcher drops out during WAIT, then stays offline.
        req_valid[1] = 1'b1;
        req_op[1]    = 1'b0;
        wait_grant(0, n);
        chk("drop_grant", 64'(grant), 64'b0010);
        tick();
        disp_online = 1'b0;
        tick();
        chk("drop_no_done_yet", 64'(done), 64'd0);
        tick();
        chk("drop_done", 64'(done), 64'b0010);
        chk("drop_err", 64'(err), 64'b0010);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (grant != '0 || msg_out != 8'h00) bad = 1'b1;
        end
        chk("offline_no_grant", 64'(bad), 64'd0);
        disp_online = 1'b1;
        wait_grant(0, n);
        chk("online_grant_latency", 64'(n), 64'd2);
        chk("online_grant", 64'(grant), 64'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_msg_arbiter.md
# thread_msg_arbiter

Arbiter and sequencer for the shared thread-dispatcher message channel. Up to N_CPU per-core thread controllers post FORK or STOP requests, each carrying a thread address and a data pointer. The block grants one request at a time in round-robin order and drives the CPU_R_FORK_THRD or CPU_R_STOP_THRD message, address and data toward the dispatcher. It then waits for the matching CPU_R_FORK_DONE or CPU_R_STOP_DONE reply and returns a per-core done or error pulse.

## Interface
- N_CPU, 4, number of requesting cores (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 1024, maximum WAIT cycles before abort; 0 disables the timeout

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_CPU  per-core request; held by the core until its done pulse
- req_op  in  N_CPU  per-core opcode: 0 = FORK, 1 = STOP
- req_addr  in  N_CPU*ADDR_W  packed thread addresses; core i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_CPU*DATA_W  packed data pointers, packed the same way
- done  out  N_CPU  one-cycle pulse to the granted core on completion
- err  out  N_CPU  one-cycle pulse, coincident with done, on abort
- grant  out  N_CPU  one-hot index of the core being served; 0 when idle
- disp_online  in  1  dispatcher present and accepting messages
- msg_out  out  8  message to dispatcher; 8'h00 = no message
- addr_out  out  ADDR_W  latched request address
- data_out  out  DATA_W  latched request data
- msg_in  in  8  dispatcher reply code

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If disp_online=1 and any req_valid=1, pick the first set bit starting at rr_ptr and wrapping modulo N_CPU.
  - Latch the granted index g, its op, addr and data.
  - Set grant to one-hot g and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - msg_out = CPU_R_FORK_THRD when op=0, CPU_R_STOP_THRD when op=1.
  - addr_out and data_out carry the latched values.
  - Go to WAIT and clear the timeout counter.
- WAIT
  - msg_out = 8'h00; addr_out and data_out keep their latched values.
  - Each cycle, compare msg_in with the expected reply: FORK_DONE for op=0, STOP_DONE for op=1.
  - Any other code, including the done code of the wrong operation, is ignored.
  - On a match, go to RESP with err_flag=0.
  - On timeout (counter = TIMEOUT_CYC-1, TIMEOUT_CYC≠0) or disp_online=0, go to RESP with err_flag=1.
- RESP (1 cycle)
  - done[g]=1 and err[g]=err_flag.
  - rr_ptr = (g+1) mod N_CPU.
  - grant is cleared and the FSM returns to IDLE.
- The latched request is authoritative. A core dropping req_valid mid-transaction does not abort the transaction; done still pulses.
- A core whose req_valid is still high in the cycle after its done pulse is treated as a new request.
- Only one transaction is in flight at a time. Other requests wait with no done output.
- When disp_online=0 in IDLE, no grant is issued and outputs remain idle.
- Timeout counter width is $clog2(TIMEOUT_CYC+1); it saturates and does not wrap.

## Timing
- All outputs are registered. Reset values:
  - msg_out=8'h00, addr_out=0, data_out=0
  - grant=0, done=0, err=0
  - rr_ptr=0, state IDLE
- Reset asserted mid-transaction returns the block to these values immediately. No done pulse is issued for the aborted request.
- Latency:
  - req_valid sampled high at edge k gives grant and msg_out valid after edge k+1.
  - msg_out returns to 00 after edge k+2.
  - A matching msg_in sampled at edge m gives done after edge m+1.
  - Minimum request-to-done is 4 cycles; back-to-back grants are separated by 1 IDLE cycle.
- msg_in is sampled only in WAIT. A reply arriving during the ISSUE cycle is missed; the dispatcher must reply no earlier than the first WAIT cycle.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Fairness guarantee: each requester is served within N_CPU transactions.

## Test plan
- Single fork: core 1 sets valid, op=0, addr=0x100, data=0x200; dispatcher replies FORK_DONE 3 cycles into WAIT.
  - Expect msg_out=FORK_THRD for 1 cycle with addr_out=0x100 and data_out=0x200.
  - Expect done[1] pulse with err=0 and rr_ptr=2.
- Round-robin: all 4 cores request together, replies are immediate.
  - Expect grant order 0,1,2,3, then core 0 again when it re-requests.
- Wrong reply: op=1 (STOP) and msg_in=FORK_DONE for 5 cycles, then STOP_DONE.
  - Expect no done until STOP_DONE; then done with err=0.
- Timeout: TIMEOUT_CYC=8 and no reply.
  - Expect done[g] and err[g] pulsed together 8 WAIT cycles after the ISSUE cycle.
- Dispatcher drop: disp_online falls in WAIT.
  - Expect done and err pulsed on the next cycle.
  - With disp_online held low, a new request gets no grant.
- Reset mid-WAIT: rst low for 1 cycle.
  - Expect all outputs 0 immediately, no done pulse, and the next grant to start from core 0.
